mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-003 SHALL have parameter READ_LAT, default 1, clock cycles from read address presented to mem_data_out valid; legal 1..4.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  request offered.
REQ-007 SHALL have port req_ready  out  1  controller accepts request.
REQ-008 SHALL have port req_write  in  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have port req_addr  in  ADDR_W  burst start address.
REQ-010 SHALL have port req_len  in  2  burst beats minus one (1..4 beats).
REQ-011 SHALL have port wr_data  in  DATA_W  write beat data.
REQ-012 SHALL have port wr_valid  in  1  write beat offered.
REQ-013 SHALL have port wr_ready  out  1  write beat accepted.
REQ-014 SHALL have port rsp_data  out  DATA_W  read beat data.
REQ-015 SHALL have port rsp_valid  out  1  read beat valid.
REQ-016 SHALL have port rsp_ready  in  1  consumer takes read beat.
REQ-017 SHALL have port busy  out  1  burst in progress.
REQ-018 SHALL have port mem_address  out  ADDR_W  to data_memory address.
REQ-019 SHALL have port mem_data_in  out  DATA_W  to data_memory data_in.
REQ-020 SHALL have port mem_rd_wrt_mode  out  1  to data_memory; 1 = write, 0 = read.
REQ-021 SHALL have port mem_data_out  in  DATA_W  from data_memory data_out.

Function
REQ-022 SHALL implement FSM states IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RD_RESP.
REQ-023 SHALL assert req_ready only in IDLE; request accepted on req_valid & req_ready; cur_addr <= req_addr, beats_left <= req_len.
REQ-024 SHALL, on accepted request, move IDLE -> WR_BEAT if req_write = 1, else IDLE -> RD_ISSUE.
REQ-025 SHALL, in WR_BEAT, drive wr_ready = 1, mem_address = cur_addr, mem_data_in = wr_data, mem_rd_wrt_mode = wr_valid (combinational).
REQ-026 SHALL, on wr_valid in WR_BEAT, increment cur_addr; if beats_left = 0 go IDLE, else decrement beats_left and stay.
REQ-027 SHALL drive mem_rd_wrt_mode = 0 in every state other than WR_BEAT with wr_valid = 1; no spurious writes.
REQ-028 SHALL, in RD_ISSUE, present cur_addr on mem_address for one cycle, then enter RD_WAIT with latency counter = READ_LAT - 1.
REQ-029 SHALL hold mem_address in RD_WAIT; when counter = 0, capture mem_data_out into rsp_data and enter RD_RESP.
REQ-030 SHALL hold rsp_valid = 1 and rsp_data stable in RD_RESP until rsp_ready = 1.
REQ-031 SHALL, on rsp_valid & rsp_ready, increment cur_addr; go IDLE if beats_left = 0, else decrement beats_left and go RD_ISSUE.
REQ-032 SHALL wrap cur_addr modulo 2^ADDR_W (255 -> 0 at default width).
REQ-033 SHALL drive busy = 1 in every state except IDLE.
REQ-034 SHALL ignore req_valid while not IDLE; the request is neither lost nor accepted until IDLE.
REQ-035 SHALL keep mem_data_in = 0 outside WR_BEAT and wr_ready = 0 outside WR_BEAT.
REQ-036 SHALL give single-beat read latency, req accept to rsp_valid, of READ_LAT + 1 cycles.

Reset
REQ-037 SHALL, on rst = 0 at any time including mid-burst, go to IDLE immediately, no further memory write issued.
REQ-038 SHALL reset values: req_ready 1 after release, wr_ready 0, rsp_valid 0, rsp_data 0, busy 0, mem_address 0, mem_data_in 0, mem_rd_wrt_mode 0.
REQ-039 SHALL reset cur_addr, beats_left and latency counter to 0.

Structure
REQ-040 SHALL place state encoding and MODE_WRITE = 1 / MODE_READ = 0 constants in shared package mem_ctrl_pkg.
REQ-041 SHALL use one sub-module, mem_lat_counter, a loadable down-counter for the READ_LAT wait.

Verification
REQ-042 SHALL check: reset release -> all outputs at REQ-038 values, req_ready = 1, busy = 0.
REQ-043 SHALL check: write addr 0x10 len 2 data 0xA1,0xA2,0xA3, wr_valid gap of 2 cycles after beat 1 -> memory 0x10..0x12 = A1,A2,A3, busy drops after beat 3.
REQ-044 SHALL check: read addr 0x10 len 2 with rsp_ready held low 3 cycles on beat 2 -> rsp_data A1,A2,A3 in order, beat 2 stable while stalled.
REQ-045 SHALL check: write addr 0xFE len 3 data 1,2,3,4 -> writes at 0xFE,0xFF,0x00,0x01.
REQ-046 SHALL check: rst asserted after beat 1 of a 4-beat write -> only first address written, outputs at reset values in same cycle.
REQ-047 SHALL check: READ_LAT = 3, single read addr 0x05 -> rsp_valid 4 cycles after accept with correct data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: the FSM state
// encoding, data_memory mode constants and the latency counter width.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RESP  = 3'd4
  } state_e;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  // Two bits cover a wait of READ_LAT - 1 = 0..3 cycles.
  localparam int LAT_CNT_W = 2;

  // Value loaded into the latency counter when a read address is issued.
  function automatic logic [LAT_CNT_W-1:0] lat_load_value(input int read_lat);
    return LAT_CNT_W'(read_lat - 1);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the wait between presenting a read
// address and the memory data being valid. Stops at zero.
module mem_lat_counter
  import mem_ctrl_pkg::*;
#(
  parameter int CNT_W = LAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Load has priority over decrement; decrement never goes below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Burst controller in front of a single-port data_memory. Accepts 1..4 beat
// read or write bursts, streams write beats straight into the memory and
// returns read beats one at a time through a valid/ready response port.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd_wrt_mode,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] cur_addr_d, cur_addr_q;
  logic [1:0]        beats_left_d, beats_left_q;
  logic [DATA_W-1:0] rsp_data_d, rsp_data_q;
  logic              lat_load;
  logic              lat_dec;
  logic              lat_zero;

  mem_lat_counter #(
    .CNT_W (LAT_CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (lat_load_value(READ_LAT)),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  // Next-state logic: burst bookkeeping, address stepping and read capture.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rsp_data_d   = rsp_data_q;
    lat_load     = 1'b0;
    lat_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_write ? WR_BEAT : RD_ISSUE;
        end
      end
      WR_BEAT: begin
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + 1'b1;
          if (beats_left_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            beats_left_d = beats_left_q - 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        lat_load = 1'b1;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_zero) begin
          rsp_data_d = mem_data_out;
          state_d    = RD_RESP;
        end else begin
          lat_dec = 1'b1;
        end
      end
      RD_RESP: begin
        if (rsp_ready) begin
          cur_addr_d = cur_addr_q + 1'b1;
          if (beats_left_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            beats_left_d = beats_left_q - 1'b1;
            state_d      = RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any burst in flight and returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Write strobe follows wr_valid only while a write beat is expected, so a
  // reset or any other state can never issue a memory write.
  assign req_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign wr_ready        = (state_q == WR_BEAT);
  assign mem_rd_wrt_mode = ((state_q == WR_BEAT) && wr_valid) ? MODE_WRITE : MODE_READ;
  assign mem_data_in     = (state_q == WR_BEAT) ? wr_data : '0;
  assign mem_address     = cur_addr_q;
  assign rsp_valid       = (state_q == RD_RESP);
  assign rsp_data        = rsp_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural data_memory, a
// reference memory image with expected write/read queues, a per-cycle
// compare process, directed scenarios and randomized bursts.
module tb_mem_access_ctrl;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       mem_preload;

  // Default-latency DUT signals.
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic [1:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid, rsp_ready, busy;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_rd_wrt_mode;

  // Latency-3 DUT signals.
  logic       l3_req_valid, l3_req_ready, l3_req_write;
  logic [7:0] l3_req_addr;
  logic [1:0] l3_req_len;
  logic [7:0] l3_wr_data;
  logic       l3_wr_valid, l3_wr_ready;
  logic [7:0] l3_rsp_data;
  logic       l3_rsp_valid, l3_rsp_ready, l3_busy;
  logic [7:0] l3_mem_address, l3_mem_data_in, l3_mem_data_out;
  logic       l3_mem_rd_wrt_mode;

  logic [7:0] mem     [256];
  logic [7:0] mem3    [256];
  logic [7:0] ref_mem [256];
  logic [7:0] mem_rd_pipe;
  logic [7:0] pipe3   [3];

  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  wr_t        cmp_w;
  logic [7:0] cmp_rd;
  logic       stall_seen;
  logic [7:0] stall_data;

  int tests;
  int fails;

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(8), .READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .busy(busy), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_rd_wrt_mode(mem_rd_wrt_mode), .mem_data_out(mem_data_out)
  );

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(8), .READ_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_write(l3_req_write), .req_addr(l3_req_addr), .req_len(l3_req_len),
    .wr_data(l3_wr_data), .wr_valid(l3_wr_valid), .wr_ready(l3_wr_ready),
    .rsp_data(l3_rsp_data), .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
    .busy(l3_busy), .mem_address(l3_mem_address), .mem_data_in(l3_mem_data_in),
    .mem_rd_wrt_mode(l3_mem_rd_wrt_mode), .mem_data_out(l3_mem_data_out)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'hC3;
  endfunction

  function automatic logic [7:0] init_val3(input int i);
    return 8'(i) ^ 8'h59;
  endfunction

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data_memory with a one-cycle read pipeline.
  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_rd_wrt_mode) begin
      mem[mem_address] <= mem_data_in;
    end
    mem_rd_pipe <= mem[mem_address];
  end
  assign mem_data_out = mem_rd_pipe;

  // Behavioural data_memory with a three-cycle read pipeline.
  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_val3(i);
    end else if (l3_mem_rd_wrt_mode) begin
      mem3[l3_mem_address] <= l3_mem_data_in;
    end
    pipe3[0] <= mem3[l3_mem_address];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign l3_mem_data_out = pipe3[2];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of memory writes, read beats and stall stability.
  always @(negedge clk) begin
    if (mem_rd_wrt_mode) begin
      if (exp_wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_address, mem_data_in);
      end else begin
        cmp_w = exp_wr_q.pop_front();
        check_output("write_addr", mem_address, cmp_w.addr);
        check_output("write_data", mem_data_in, cmp_w.data);
      end
    end
    if (!wr_ready) check_output("data_in_idle_zero", mem_data_in, 0);
    if (stall_seen) begin
      check_output("stall_valid_held", rsp_valid, 1);
      check_output("stall_data_stable", rsp_data, stall_data);
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_read_beat: data 0x%0h, expected none", rsp_data);
      end else begin
        cmp_rd = exp_rd_q.pop_front();
        check_output("read_data", rsp_data, cmp_rd);
      end
    end
    stall_seen = rst && rsp_valid && !rsp_ready;
    stall_data = rsp_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic wr, input logic [7:0] addr, input logic [1:0] len);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check_output("req_ready_before_accept", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drive_noise(input bit noise);
    if (noise) begin
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_len   = 2'($urandom);
    end
  endtask

  task automatic do_write_burst(input logic [7:0] addr, input logic [1:0] len, input logic [31:0] data,
                                input int gap1, input bit rand_gaps, input bit noise);
    logic [7:0] a;
    logic [7:0] d;
    int g;
    apply_stimulus(1'b1, addr, len);
    drive_noise(noise);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      d = data[8*i +: 8];
      g = rand_gaps ? int'($urandom_range(0, 2)) : ((i == 1) ? gap1 : 0);
      for (int k = 0; k < g; k++) begin
        wr_data = 8'($urandom);
        check_output("busy_in_gap", busy, 1);
        step();
      end
      exp_wr_q.push_back('{addr: a, data: d});
      ref_mem[a] = d;
      check_output("wr_ready_in_burst", wr_ready, 1);
      wr_valid = 1'b1;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
      wr_data  = 8'($urandom);
    end
    req_valid = 1'b0;
    check_output("busy_after_write", busy, 0);
  endtask

  task automatic do_read_burst(input logic [7:0] addr, input logic [1:0] len, input int stall_beat,
                               input int stall_cycles, input bit rand_ready, input bit noise,
                               output logic [31:0] got, output int lat);
    logic [7:0] a;
    int n;
    int s;
    got = '0;
    lat = 0;
    apply_stimulus(1'b0, addr, len);
    drive_noise(noise);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      exp_rd_q.push_back(ref_mem[a]);
      n = 0;
      while (!rsp_valid && n < 20) begin
        step();
        n++;
      end
      if (i == 0) lat = n;
      check_output("rsp_valid_within_bound", rsp_valid, 1);
      s = rand_ready ? int'($urandom_range(0, 3)) : ((i == stall_beat) ? stall_cycles : 0);
      for (int k = 0; k < s; k++) step();
      got[8*i +: 8] = rsp_data;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    req_valid = 1'b0;
    check_output("busy_after_read", busy, 0);
  endtask

  // Directed scenarios followed by randomized bursts.
  initial begin
    logic [31:0] got;
    int lat;
    logic [7:0] old41;
    int n;
    tests = 0;
    fails = 0;
    stall_seen = 1'b0;
    stall_data = '0;
    rst = 1'b0;
    mem_preload = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wr_data = 0; wr_valid = 0; rsp_ready = 0;
    l3_req_valid = 0; l3_req_write = 0; l3_req_addr = 0; l3_req_len = 0;
    l3_wr_data = 0; l3_wr_valid = 0; l3_rsp_ready = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    step();
    step();
    mem_preload = 1'b0;
    rst = 1'b1;
    step();

    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_wr_ready", wr_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_mem_address", mem_address, 0);
    check_output("rst_mem_data_in", mem_data_in, 0);
    check_output("rst_mem_mode", mem_rd_wrt_mode, 0);

    do_write_burst(8'h10, 2'd2, 32'h00A3A2A1, 2, 1'b0, 1'b0);
    step();
    check_output("mem_10", mem[8'h10], 8'hA1);
    check_output("mem_11", mem[8'h11], 8'hA2);
    check_output("mem_12", mem[8'h12], 8'hA3);

    do_read_burst(8'h10, 2'd2, 1, 3, 1'b0, 1'b0, got, lat);
    check_output("read_10_beats", got, 32'h00A3A2A1);
    check_output("read_first_latency", lat, 2);

    do_write_burst(8'hFE, 2'd3, 32'h04030201, 0, 1'b0, 1'b0);
    step();
    check_output("mem_FE", mem[8'hFE], 8'h01);
    check_output("mem_FF", mem[8'hFF], 8'h02);
    check_output("mem_00", mem[8'h00], 8'h03);
    check_output("mem_01", mem[8'h01], 8'h04);

    do_read_burst(8'hFF, 2'd0, 0, 0, 1'b0, 1'b0, got, lat);
    check_output("single_read_data", got, 32'h00000002);
    check_output("single_read_latency", lat, 2);

    // Reset in the middle of a four-beat write.
    old41 = ref_mem[8'h41];
    apply_stimulus(1'b1, 8'h40, 2'd3);
    exp_wr_q.push_back('{addr: 8'h40, data: 8'h11});
    ref_mem[8'h40] = 8'h11;
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    step();
    wr_data = 8'h22;
    #2;
    rst = 1'b0;
    #1;
    check_output("midrst_req_ready", req_ready, 1);
    check_output("midrst_wr_ready", wr_ready, 0);
    check_output("midrst_rsp_valid", rsp_valid, 0);
    check_output("midrst_rsp_data", rsp_data, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_mem_address", mem_address, 0);
    check_output("midrst_mem_data_in", mem_data_in, 0);
    check_output("midrst_mem_mode", mem_rd_wrt_mode, 0);
    step();
    step();
    wr_valid = 1'b0;
    rst = 1'b1;
    step();
    check_output("midrst_mem_40", mem[8'h40], 8'h11);
    check_output("midrst_mem_41", mem[8'h41], old41);
    check_output("midrst_no_pending_write", exp_wr_q.size(), 0);

    // Single read on the latency-3 instance.
    check_output("l3_req_ready", l3_req_ready, 1);
    l3_req_valid = 1'b1;
    l3_req_addr  = 8'h05;
    l3_req_len   = 2'd0;
    step();
    l3_req_valid = 1'b0;
    n = 0;
    while (!l3_rsp_valid && n < 20) begin
      step();
      n++;
    end
    check_output("l3_latency", n, 4);
    check_output("l3_rsp_data", l3_rsp_data, 8'h5C);
    l3_rsp_ready = 1'b1;
    step();
    l3_rsp_ready = 1'b0;
    check_output("l3_busy_after", l3_busy, 0);

    // Randomized bursts with gaps, stalls and requests offered while busy.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write_burst(8'($urandom), 2'($urandom), $urandom, 0, 1'b1, 1'($urandom_range(0, 1)));
      end else begin
        do_read_burst(8'($urandom), 2'($urandom), 0, 0, 1'b1, 1'($urandom_range(0, 1)), got, lat);
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end

    step();
    check_output("writes_all_seen", exp_wr_q.size(), 0);
    check_output("reads_all_seen", exp_rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
